// File: rtl/video_timing_gen.sv
// -----------------------------------------------------------------------------
// video_timing_gen
//
// Raster timing generator. Horizontal and vertical counters scan the full
// frame (visible area plus porches and sync) and drive x/y directly. The sync,
// active and start-pulse outputs are decoded from the *next* counter values
// and registered together with the counters, so every output describes the
// x/y present in the same cycle.
//
// Geometry: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP and
//           V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP, both limited to 1024 so the
//           10-bit position outputs can hold every position.
//
// Ports
//   clk          single clock, rising edge
//   reset        synchronous, active-high; parks the scan at the last position
//   pix_en       pixel-advance enable; all state holds while low
//   x, y         current horizontal / vertical position
//   hsync, vsync sync outputs, asserted level set by SYNC_POL
//   active       (x,y) is inside the visible area
//   line_start   one-cycle pulse when x becomes 0
//   frame_start  one-cycle pulse when (x,y) becomes (0,0)
//   frame_count  frames started since reset, wraps at 16 bits
// -----------------------------------------------------------------------------
module video_timing_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int SYNC_POL = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        pix_en,
  output logic [9:0]  x,
  output logic [9:0]  y,
  output logic        hsync,
  output logic        vsync,
  output logic        active,
  output logic        line_start,
  output logic        frame_start,
  output logic [15:0] frame_count
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam int HS_START = H_ACTIVE + H_FP;
  localparam int HS_END   = H_ACTIVE + H_FP + H_SYNC;
  localparam int VS_START = V_ACTIVE + V_FP;
  localparam int VS_END   = V_ACTIVE + V_FP + V_SYNC;

  localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);

  localparam logic SYNC_ON  = (SYNC_POL != 0);
  localparam logic SYNC_OFF = !SYNC_ON;

  if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_bad_geometry
    $error("video_timing_gen: H_TOTAL and V_TOTAL must not exceed 1024");
  end

  // Half-open range test lo <= v < hi on a counter value.
  function automatic logic in_range(input logic [9:0] v, input int lo, input int hi);
    return (int'(v) >= lo) && (int'(v) < hi);
  endfunction

  function automatic logic sync_level(input logic asserted);
    return asserted ? SYNC_ON : SYNC_OFF;
  endfunction

  logic [9:0] x_next;
  logic [9:0] y_next;
  logic       h_wrap;
  logic       sof_next;

  always_comb begin
    h_wrap   = (x == H_LAST);
    x_next   = h_wrap ? 10'd0 : x + 10'd1;
    y_next   = y;
    if (h_wrap) begin
      y_next = (y == V_LAST) ? 10'd0 : y + 10'd1;
    end
    sof_next = (x_next == 10'd0) && (y_next == 10'd0);
  end

  // Registered stage: counters and every decoded output advance together,
  // decoded from the next counter values so there is no skew against x/y.
  // vsync depends on y only, so it can only change when the line wraps.
  always_ff @(posedge clk) begin
    if (reset) begin
      x           <= H_LAST;
      y           <= V_LAST;
      active      <= 1'b0;
      hsync       <= SYNC_OFF;
      vsync       <= SYNC_OFF;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      frame_count <= 16'd0;
    end else begin
      // Pulses are one clock wide even when pix_en drops afterwards.
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      if (pix_en) begin
        x           <= x_next;
        y           <= y_next;
        active      <= in_range(x_next, 0, H_ACTIVE) && in_range(y_next, 0, V_ACTIVE);
        hsync       <= sync_level(in_range(x_next, HS_START, HS_END));
        vsync       <= sync_level(in_range(y_next, VS_START, VS_END));
        line_start  <= (x_next == 10'd0);
        frame_start <= sof_next;
        if (sof_next) begin
          frame_count <= frame_count + 16'd1;
        end
      end
    end
  end

endmodule

// File: doc/video_timing_gen.md
VIDEO_TIMING_GEN -- requirements
Module: video_timing_gen

Interface
REQ-001 SHALL provide parameters (name, default, meaning), one per line:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch in pixels
- H_SYNC, 96, horizontal sync width in pixels
- H_BP, 48, horizontal back porch in pixels
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch in lines
- V_SYNC, 2, vertical sync width in lines
- V_BP, 33, vertical back porch in lines
- SYNC_POL, 0, asserted sync level (0 = active-low)
REQ-002 SHALL provide ports (name, direction, width, meaning), one per line:
- clk, input, 1, single clock; all logic on rising edge
- reset, input, 1, synchronous, active-high
- pix_en, input, 1, pixel-advance enable
- x, output, 10, current horizontal position
- y, output, 10, current vertical position
- hsync, output, 1, horizontal sync
- vsync, output, 1, vertical sync
- active, output, 1, (x,y) lies in the visible area
- line_start, output, 1, one-clk pulse when x becomes 0
- frame_start, output, 1, one-clk pulse when (x,y) becomes (0,0)
- frame_count, output, 16, frames started since reset
REQ-003 SHALL define H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800) and V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (525); both totals SHALL be at most 1024.

Function
REQ-004 SHALL hold horizontal and vertical counters that drive x and y directly; all outputs SHALL be registered.
REQ-005 On a clk edge with pix_en=1, x SHALL advance by 1; at x=H_TOTAL-1, x SHALL wrap to 0 and y SHALL advance by 1.
REQ-006 When y=V_TOTAL-1 and a line wrap occurs, y SHALL wrap to 0.
REQ-007 With pix_en=0, x, y, hsync, vsync, active and frame_count SHALL hold their values.
REQ-008 In every cycle, hsync, vsync and active SHALL describe the x,y values present in that same cycle, with zero skew.
REQ-009 active SHALL be 1 iff x < H_ACTIVE and y < V_ACTIVE.
REQ-010 hsync SHALL equal SYNC_POL iff H_ACTIVE+H_FP <= x < H_ACTIVE+H_FP+H_SYNC (656..751), and SHALL equal ~SYNC_POL otherwise.
REQ-011 vsync SHALL equal SYNC_POL iff V_ACTIVE+V_FP <= y < V_ACTIVE+V_FP+V_SYNC (490..491), for the full length of those lines, and SHALL equal ~SYNC_POL otherwise.
REQ-012 line_start SHALL be 1 for exactly one clk cycle: the cycle in which x first shows 0 after a pix_en advance.
REQ-013 line_start SHALL clear on the next clk edge even if pix_en=0.
REQ-014 frame_start SHALL follow the same one-clk pulse rule as line_start, for the cycle in which (x,y) first shows (0,0).
REQ-015 line_start SHALL also be 1 in any cycle where frame_start is 1.
REQ-016 frame_count SHALL increment by 1 with each frame_start, wrapping from 16'hFFFF to 0.
REQ-017 Downstream blocks SHALL be able to latch per-frame parameters on the vsync assertion edge; vsync SHALL be glitch-free, changing only at line wrap.

Reset
REQ-018 While reset=1 at a clk edge (regardless of pix_en), the block SHALL load:
- x = H_TOTAL-1 (799), y = V_TOTAL-1 (524)
- active = 0
- hsync = vsync = ~SYNC_POL
- line_start = frame_start = 0
- frame_count = 0
REQ-019 The first pix_en=1 edge after reset release SHALL produce x=0, y=0, active=1, line_start=1, frame_start=1 and frame_count=1.
REQ-020 Reset asserted mid-frame SHALL abort the frame with no partial pulses, and the next frame SHALL start per REQ-019.

Verification
REQ-021 The bench SHALL cover these directed scenarios:
- Reset, then pix_en=1 constant -> next cycle x=0, y=0, active=1, frame_start=1, line_start=1, frame_count=1; following cycle both pulses 0.
- Scan line 0 -> active falls when x=640; hsync=0 for x=656..751 (96 cycles); at x=799 -> x=0, y=1, line_start=1, frame_start=0.
- Run the frame -> vsync=0 exactly while y=490..491 (1600 pix_en cycles); active=0 for y>=480.
- 420000 pix_en cycles after the first frame_start -> second frame_start, frame_count=2; force 16'hFFFF then cross a frame -> 0.
- pix_en toggling 1,0,1,0 -> x advances every second clk; line_start/frame_start stay exactly one clk wide; outputs hold on pix_en=0 cycles.
- Reset asserted at x=700, y=300 with pix_en=1 -> x=799, y=524, active=0, syncs inactive, frame_count=0; release -> REQ-019 sequence.
